// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory port.
package mem_arbiter_pkg;

    typedef logic [31:0] rvwordT;
    typedef logic [2:0]  EpochT;

    localparam EpochT EPOCH_INVALID = 3'b111;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } MemControlT;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } MemOwnerT;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data traffic onto one single-port memory; grant is same-cycle,
// read data returns one cycle later. A requester stalls by holding its request until granted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int STARVE_MAX = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  rvwordT                if_addr,
    input  EpochT                 if_epoch,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output rvwordT                if_rdata,
    output EpochT                 if_repoch,
    input  MemControlT            dm_control,
    input  rvwordT                dm_addr,
    input  rvwordT                dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output rvwordT                dm_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output rvwordT                mem_wdata,
    input  rvwordT                mem_rdata
);

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    MemOwnerT   owner_q, owner_d;
    logic [1:0] starve_cnt_q, starve_cnt_d;
    EpochT      if_repoch_q, if_repoch_d;

    logic dm_pend;
    logic fetch_win;

    // Byte-offset bits and address bits above the memory size are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr, dm_addr};

    always_comb begin
        dm_pend   = (dm_control != MEM_NONE);
        fetch_win = if_req && (!dm_pend || (starve_cnt_q == STARVE_LIM));
        // Grants are suppressed while in reset so nothing reaches memory.
        if_gnt    = !rst && fetch_win;
        dm_gnt    = !rst && dm_pend && !fetch_win;

        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = dm_wdata;
        if (if_gnt) begin
            mem_addr = if_addr[ADDR_WIDTH+1:2];
        end else if (dm_gnt) begin
            mem_addr = dm_addr[ADDR_WIDTH+1:2];
            mem_we   = (dm_control == MEM_WRITE);
        end

        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 2'd0;
        end else if (dm_gnt && (starve_cnt_q != 2'd3)) begin
            starve_cnt_d = starve_cnt_q + 2'd1;
        end

        owner_d     = OWN_NONE;
        if_repoch_d = if_repoch_q;
        if (if_gnt) begin
            owner_d     = OWN_FETCH;
            if_repoch_d = if_epoch;
        end else if (dm_gnt && (dm_control == MEM_READ)) begin
            owner_d = OWN_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= 2'd0;
            if_repoch_q  <= EPOCH_INVALID;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            if_repoch_q  <= if_repoch_d;
        end
    end

    assign if_rvalid = (owner_q == OWN_FETCH);
    assign dm_rvalid = (owner_q == OWN_DATA);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign if_repoch = if_repoch_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    rvwordT        if_addr = '0;
    EpochT         if_epoch = '0;
    logic          if_gnt;
    logic          if_rvalid;
    rvwordT        if_rdata;
    EpochT         if_repoch;
    MemControlT    dm_control = MEM_NONE;
    rvwordT        dm_addr = '0;
    rvwordT        dm_wdata = '0;
    logic          dm_gnt;
    logic          dm_rvalid;
    rvwordT        dm_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    rvwordT        mem_wdata;
    rvwordT        mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    rvwordT mem_model [256];

    mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_epoch(if_epoch),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_repoch(if_repoch),
        .dm_control(dm_control), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic rvwordT word_init(int i);
        logic [15:0] idx;
        idx = 16'(i);
        return {16'hC0DE, idx};
    endfunction

    // Memory contents are reloaded while reset is held; word 4 holds a known instruction.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= word_init(i);
            mem_model[4] <= 32'h0050_0093;
        end else if (mem_we) begin
            mem_model[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem_model[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req     = 1'b0;
        dm_control = MEM_NONE;
    endtask

    initial begin
        logic [7:0] pat;
        int k;
        int prev_k;

        // Reset with a write presented: nothing may reach memory.
        if_req = 1'b1; if_addr = 32'h10; if_epoch = 3'd1;
        dm_control = MEM_WRITE; dm_addr = 32'h44; dm_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("rst_if_repoch", 32'(if_repoch), 32'(EPOCH_INVALID));

        // Fetch only, issued in the first cycle after reset release.
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h10; if_epoch = 3'd1; dm_control = MEM_NONE;
        #1;
        check("f_if_gnt", 32'(if_gnt), 32'd1);
        check("f_dm_gnt", 32'(dm_gnt), 32'd0);
        check("f_mem_addr", 32'(mem_addr), 32'd4);
        @(negedge clk);
        idle_inputs();
        #1;
        check("f_if_rvalid", 32'(if_rvalid), 32'd1);
        check("f_if_rdata", if_rdata, 32'h0050_0093);
        check("f_if_repoch", 32'(if_repoch), 32'd1);
        check("f_dm_rvalid", 32'(dm_rvalid), 32'd0);

        // Data write then read-back of the same word.
        @(negedge clk);
        dm_control = MEM_WRITE; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        #1;
        check("w_dm_gnt", 32'(dm_gnt), 32'd1);
        check("w_mem_we", 32'(mem_we), 32'd1);
        check("w_mem_addr", 32'(mem_addr), 32'h10);
        check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        dm_control = MEM_READ; dm_addr = 32'h40;
        #1;
        check("r_dm_gnt", 32'(dm_gnt), 32'd1);
        check("r_mem_we", 32'(mem_we), 32'd0);
        check("w_no_dm_rvalid", 32'(dm_rvalid), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("r_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check("r_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        check("r_if_rvalid", 32'(if_rvalid), 32'd0);

        // Contention: fetch held high against six data reads -> D,D,F,D,D,F,D,D.
        pat = 8'b0010_0100;
        k = 0;
        prev_k = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if_req = (c < 8); if_addr = 32'h20; if_epoch = 3'd2;
            dm_control = (k < 6) ? MEM_READ : MEM_NONE;
            dm_addr = 32'h80 + 32'(4 * k);
            #1;
            if (c > 0) begin
                if (pat[c-1]) begin
                    check($sformatf("c%0d_if_rvalid", c), 32'(if_rvalid), 32'd1);
                    check($sformatf("c%0d_dm_rvalid", c), 32'(dm_rvalid), 32'd0);
                    check($sformatf("c%0d_if_rdata", c), if_rdata, word_init(8));
                end else begin
                    check($sformatf("c%0d_dm_rvalid", c), 32'(dm_rvalid), 32'd1);
                    check($sformatf("c%0d_if_rvalid", c), 32'(if_rvalid), 32'd0);
                    check($sformatf("c%0d_dm_rdata", c), dm_rdata, word_init(32 + prev_k));
                end
            end
            if (c < 8) begin
                check($sformatf("c%0d_if_gnt", c), 32'(if_gnt), 32'(pat[c]));
                check($sformatf("c%0d_dm_gnt", c), 32'(dm_gnt), 32'(!pat[c]));
                if (!pat[c]) begin
                    prev_k = k;
                    k++;
                end
            end
        end

        // Idle fetch: data alternates with MEM_NONE, no fetch grant ever.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if_req = 1'b0;
            dm_control = (c % 2 == 0) ? MEM_READ : MEM_NONE;
            dm_addr = 32'h84;
            #1;
            check($sformatf("idle%0d_if_gnt", c), 32'(if_gnt), 32'd0);
            check($sformatf("idle%0d_dm_gnt", c), 32'(dm_gnt), 32'((c % 2) == 0));
        end
        // The starvation count must be back at zero: expect D,D,F again.
        pat = 8'b0000_0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h20; if_epoch = 3'd2;
            dm_control = MEM_READ; dm_addr = 32'h88;
            #1;
            check($sformatf("post_idle%0d_if_gnt", c), 32'(if_gnt), 32'(pat[c]));
        end

        // Epoch tagging on consecutive fetch grants.
        @(negedge clk);
        dm_control = MEM_NONE;
        if_req = 1'b1; if_addr = 32'h10; if_epoch = 3'd1;
        #1;
        check("e1_if_gnt", 32'(if_gnt), 32'd1);
        @(negedge clk);
        if_addr = 32'h14; if_epoch = 3'd2;
        #1;
        check("e2_if_gnt", 32'(if_gnt), 32'd1);
        check("e1_if_repoch", 32'(if_repoch), 32'd1);
        check("e1_if_rdata", if_rdata, 32'h0050_0093);
        @(negedge clk);
        idle_inputs();
        #1;
        check("e2_if_rvalid", 32'(if_rvalid), 32'd1);
        check("e2_if_repoch", 32'(if_repoch), 32'd2);
        check("e2_if_rdata", if_rdata, word_init(5));

        // Reset asserted while a data read is in flight.
        @(negedge clk);
        dm_control = MEM_READ; dm_addr = 32'h40;
        #1;
        check("rr_dm_gnt", 32'(dm_gnt), 32'd1);
        #1;
        rst = 1'b1;
        @(negedge clk);
        dm_control = MEM_WRITE; dm_addr = 32'h48; dm_wdata = 32'hBAD0_BAD0;
        #1;
        check("rr_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("rr_if_repoch", 32'(if_repoch), 32'(EPOCH_INVALID));
        check("rr_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        #1;
        check("rr_mem_we_2", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dm_control = MEM_NONE;
        if_req = 1'b1; if_addr = 32'h10; if_epoch = 3'd3;
        #1;
        check("rr_rel_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("rr_rel_if_gnt", 32'(if_gnt), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rr_rel_if_rvalid", 32'(if_rvalid), 32'd1);
        check("rr_rel_if_repoch", 32'(if_repoch), 32'd3);
        check("rr_rel_dm_rvalid2", 32'(dm_rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
